// File: rtl/hazard_ctrl.sv
// Hazard control for a 5-stage MIPS-style pipeline: load-use / branch-operand stalls, taken-branch flush, data-memory freeze.
// Latency: all control outputs are combinational from state, rem and current inputs (same-cycle response).
// Backpressure: dmem_busy_i freezes the back half and holds PC/IF-ID; the pending stall resumes once it drops.
//
// Ports:
//   clk_i, rst_n_i                       clock, synchronous active-low reset
//   ex_memread_i, ex_regwrite_i          EX-stage instruction is a load / writes a register
//   ex_wr_addr_i                         EX-stage destination register
//   id_rs_i, id_rt_i, id_uses_rt_i       ID-stage source registers, rt-used flag
//   id_is_branch_i, branch_taken_i       ID-stage branch compare, resolved taken
//   dmem_busy_i                          data memory not ready
//   pc_write_o, if_id_write_o            PC / IF-ID update enables
//   if_id_flush_o, id_ex_bubble_o        IF-ID clear, ID-EX control bubble
//   pipe_freeze_o                        hold ID-EX, EX-MEM, MEM-WB
//   stall_cnt_o, flush_cnt_o             saturating performance counters
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             ex_memread_i,
    input  logic             ex_regwrite_i,
    input  logic [4:0]       ex_wr_addr_i,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic             id_uses_rt_i,
    input  logic             id_is_branch_i,
    input  logic             branch_taken_i,
    input  logic             dmem_busy_i,
    output logic             pc_write_o,
    output logic             if_id_write_o,
    output logic             if_id_flush_o,
    output logic             id_ex_bubble_o,
    output logic             pipe_freeze_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        STALL    = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t     state_q, state_d;
    state_t     ret_q, ret_d;      // state to resume once the memory wait ends
    state_t     eff_state;
    logic [1:0] rem_q, rem_d;
    logic [1:0] need;
    logic       match;

    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    // Register dependence between EX destination and ID sources; $zero never hazards.
    always_comb begin
        match = (ex_wr_addr_i != 5'd0) &&
                ((ex_wr_addr_i == id_rs_i) || (id_uses_rt_i && (ex_wr_addr_i == id_rt_i)));
        need = 2'd0;
        if (ex_memread_i && match && id_is_branch_i) begin
            need = 2'd2;
        end else if (ex_memread_i && match) begin
            need = 2'd1;
        end else if (ex_regwrite_i && match && id_is_branch_i) begin
            need = 2'd1;
        end
    end

    // In MEM_WAIT the cycle busy drops already behaves as the held state, so
    // no dead cycle is inserted between the freeze and the resumed work.
    assign eff_state = (state_q == MEM_WAIT) ? ret_q : state_q;

    always_comb begin
        pc_write_o     = 1'b1;
        if_id_write_o  = 1'b1;
        if_id_flush_o  = 1'b0;
        id_ex_bubble_o = 1'b0;
        pipe_freeze_o  = 1'b0;
        state_d        = eff_state;
        ret_d          = ret_q;
        rem_d          = rem_q;

        if (!rst_n_i) begin
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            if_id_flush_o  = 1'b1;
            id_ex_bubble_o = 1'b1;
            state_d        = RUN;
            ret_d          = RUN;
            rem_d          = 2'd0;
        end else if (dmem_busy_i) begin
            pc_write_o    = 1'b0;
            if_id_write_o = 1'b0;
            pipe_freeze_o = 1'b1;
            state_d       = MEM_WAIT;
            ret_d         = eff_state;
        end else if (eff_state == STALL) begin
            // Committed stall: hazard inputs may have moved on, keep stalling.
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            id_ex_bubble_o = 1'b1;
            rem_d          = rem_q - 2'd1;
            state_d        = (rem_q <= 2'd1) ? RUN : STALL;
        end else if (need != 2'd0) begin
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            id_ex_bubble_o = 1'b1;
            if (need == 2'd2) begin
                state_d = STALL;
                rem_d   = 2'd1;
            end else begin
                state_d = RUN;
                rem_d   = 2'd0;
            end
        end else if (branch_taken_i) begin
            if_id_flush_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= RUN;
            ret_q       <= RUN;
            rem_q       <= 2'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            rem_q   <= rem_d;
            if ((id_ex_bubble_o || pipe_freeze_o) && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_q <= stall_cnt_q + CNT_ONE;
            end
            if (if_id_flush_o && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_q <= flush_cnt_q + CNT_ONE;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic       ex_memread_i, ex_regwrite_i, id_uses_rt_i, id_is_branch_i;
    logic       branch_taken_i, dmem_busy_i;
    logic [4:0] ex_wr_addr_i, id_rs_i, id_rt_i;

    logic        pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o, pipe_freeze_o;
    logic [15:0] stall_cnt_o, flush_cnt_o;
    logic        pc_write4, if_id_write4, if_id_flush4, id_ex_bubble4, pipe_freeze4;
    logic [3:0]  stall_cnt4, flush_cnt4;

    int checks   = 0;
    int failures = 0;

    // Output vector {pc_write, if_id_write, flush, bubble, freeze}
    localparam logic [4:0] O_NORM   = 5'b11000;
    localparam logic [4:0] O_STALL  = 5'b00010;
    localparam logic [4:0] O_FREEZE = 5'b00001;
    localparam logic [4:0] O_FLUSH  = 5'b11100;
    localparam logic [4:0] O_RESET  = 5'b00110;

    logic [4:0] outs;
    assign outs = {pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o, pipe_freeze_o};

    always #5 clk_i = ~clk_i;

    hazard_ctrl dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .ex_memread_i(ex_memread_i), .ex_regwrite_i(ex_regwrite_i), .ex_wr_addr_i(ex_wr_addr_i),
        .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_uses_rt_i(id_uses_rt_i),
        .id_is_branch_i(id_is_branch_i), .branch_taken_i(branch_taken_i), .dmem_busy_i(dmem_busy_i),
        .pc_write_o(pc_write_o), .if_id_write_o(if_id_write_o), .if_id_flush_o(if_id_flush_o),
        .id_ex_bubble_o(id_ex_bubble_o), .pipe_freeze_o(pipe_freeze_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    hazard_ctrl #(.CNT_W(4)) dut4 (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .ex_memread_i(ex_memread_i), .ex_regwrite_i(ex_regwrite_i), .ex_wr_addr_i(ex_wr_addr_i),
        .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_uses_rt_i(id_uses_rt_i),
        .id_is_branch_i(id_is_branch_i), .branch_taken_i(branch_taken_i), .dmem_busy_i(dmem_busy_i),
        .pc_write_o(pc_write4), .if_id_write_o(if_id_write4), .if_id_flush_o(if_id_flush4),
        .id_ex_bubble_o(id_ex_bubble4), .pipe_freeze_o(pipe_freeze4),
        .stall_cnt_o(stall_cnt4), .flush_cnt_o(flush_cnt4)
    );

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        ex_memread_i   = 1'b0; ex_regwrite_i = 1'b0; ex_wr_addr_i = 5'd0;
        id_rs_i        = 5'd0; id_rt_i       = 5'd0; id_uses_rt_i = 1'b0;
        id_is_branch_i = 1'b0; branch_taken_i = 1'b0; dmem_busy_i = 1'b0;
    endtask

    task automatic load_use();
        idle();
        ex_memread_i = 1'b1; ex_wr_addr_i = 5'd5; id_rs_i = 5'd5;
    endtask

    task automatic load_branch();
        idle();
        ex_memread_i = 1'b1; ex_wr_addr_i = 5'd8; id_rt_i = 5'd8;
        id_uses_rt_i = 1'b1; id_is_branch_i = 1'b1;
    endtask

    task automatic do_reset();
        idle();
        rst_n_i = 1'b0;
        step();
        rst_n_i = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        idle();
        #1;
        checks++;
        if (outs !== O_RESET) begin
            failures++; $display("FAIL reset_outs got=%b exp=%b", outs, O_RESET);
        end
        step();
        rst_n_i = 1'b1;
        #1;
        checks++;
        if (stall_cnt_o !== 16'd0 || flush_cnt_o !== 16'd0) begin
            failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt_o, flush_cnt_o);
        end
        checks++;
        if (outs !== O_NORM) begin
            failures++; $display("FAIL reset_run got=%b exp=%b", outs, O_NORM);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        load_use();
        #1;
        checks++;
        if (outs !== O_STALL) begin
            failures++; $display("FAIL load_use_stall got=%b exp=%b", outs, O_STALL);
        end
        step();
        idle();
        #1;
        checks++;
        if (outs !== O_NORM) begin
            failures++; $display("FAIL load_use_resume got=%b exp=%b", outs, O_NORM);
        end
        checks++;
        if (stall_cnt_o !== 16'd1) begin
            failures++; $display("FAIL load_use_cnt got=%0d exp=1", stall_cnt_o);
        end
    endtask

    task automatic test_load_branch();
        do_reset();
        load_branch();
        #1;
        checks++;
        if (outs !== O_STALL) begin
            failures++; $display("FAIL ldbr_c1 got=%b exp=%b", outs, O_STALL);
        end
        step();
        idle();
        #1;
        checks++;
        if (outs !== O_STALL) begin
            failures++; $display("FAIL ldbr_c2 got=%b exp=%b", outs, O_STALL);
        end
        step();
        checks++;
        if (outs !== O_NORM) begin
            failures++; $display("FAIL ldbr_c3 got=%b exp=%b", outs, O_NORM);
        end
        checks++;
        if (stall_cnt_o !== 16'd2) begin
            failures++; $display("FAIL ldbr_cnt got=%0d exp=2", stall_cnt_o);
        end
    endtask

    task automatic test_match_rules();
        do_reset();
        idle();
        ex_memread_i = 1'b1; ex_wr_addr_i = 5'd0; id_rs_i = 5'd0;
        #1;
        checks++;
        if (outs !== O_NORM) begin
            failures++; $display("FAIL zero_reg got=%b exp=%b", outs, O_NORM);
        end
        // rt matches but is not a source
        idle();
        ex_memread_i = 1'b1; ex_wr_addr_i = 5'd9; id_rt_i = 5'd9; id_rs_i = 5'd3;
        #1;
        checks++;
        if (outs !== O_NORM) begin
            failures++; $display("FAIL rt_unused got=%b exp=%b", outs, O_NORM);
        end
        // ALU result feeding an ID branch compare: one stall cycle
        idle();
        ex_regwrite_i = 1'b1; ex_wr_addr_i = 5'd4; id_rs_i = 5'd4; id_is_branch_i = 1'b1;
        #1;
        checks++;
        if (outs !== O_STALL) begin
            failures++; $display("FAIL alu_branch got=%b exp=%b", outs, O_STALL);
        end
        step();
        idle();
        #1;
        checks++;
        if (outs !== O_NORM) begin
            failures++; $display("FAIL alu_branch_resume got=%b exp=%b", outs, O_NORM);
        end
        // ALU result to non-branch consumer: forwarded, no stall
        ex_regwrite_i = 1'b1; ex_wr_addr_i = 5'd4; id_rs_i = 5'd4;
        #1;
        checks++;
        if (outs !== O_NORM) begin
            failures++; $display("FAIL alu_fwd got=%b exp=%b", outs, O_NORM);
        end
    endtask

    task automatic test_busy_mid_stall();
        do_reset();
        load_branch();
        #1;
        step();
        idle();
        dmem_busy_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (outs !== O_FREEZE) begin
                failures++; $display("FAIL busy_freeze%0d got=%b exp=%b", i, outs, O_FREEZE);
            end
            step();
        end
        dmem_busy_i = 1'b0;
        branch_taken_i = 1'b1;  // must be ignored in the resumed stall cycle
        #1;
        checks++;
        if (outs !== O_STALL) begin
            failures++; $display("FAIL busy_resume_stall got=%b exp=%b", outs, O_STALL);
        end
        step();
        branch_taken_i = 1'b0;
        #1;
        checks++;
        if (outs !== O_NORM) begin
            failures++; $display("FAIL busy_done got=%b exp=%b", outs, O_NORM);
        end
        checks++;
        if (stall_cnt_o !== 16'd5 || flush_cnt_o !== 16'd0) begin
            failures++; $display("FAIL busy_cnt got=%0d/%0d exp=5/0", stall_cnt_o, flush_cnt_o);
        end
    endtask

    task automatic test_branch_vs_hazard();
        do_reset();
        load_use();
        branch_taken_i = 1'b1;
        #1;
        checks++;
        if (outs !== O_STALL) begin
            failures++; $display("FAIL br_hazard got=%b exp=%b", outs, O_STALL);
        end
        step();
        idle();
        branch_taken_i = 1'b1;
        #1;
        checks++;
        if (outs !== O_FLUSH) begin
            failures++; $display("FAIL br_flush got=%b exp=%b", outs, O_FLUSH);
        end
        step();
        // busy beats a taken branch
        dmem_busy_i = 1'b1;
        #1;
        checks++;
        if (outs !== O_FREEZE) begin
            failures++; $display("FAIL br_busy got=%b exp=%b", outs, O_FREEZE);
        end
        step();
        idle();
        #1;
        checks++;
        if (flush_cnt_o !== 16'd1 || stall_cnt_o !== 16'd2) begin
            failures++; $display("FAIL br_cnt got=%0d/%0d exp=1/2", flush_cnt_o, stall_cnt_o);
        end
    endtask

    task automatic test_reset_mid_stall_and_sat();
        do_reset();
        load_branch();
        #1;
        step();
        idle();
        rst_n_i = 1'b0;
        #1;
        checks++;
        if (outs !== O_RESET) begin
            failures++; $display("FAIL rst_stall_outs got=%b exp=%b", outs, O_RESET);
        end
        step();
        rst_n_i = 1'b1;
        #1;
        checks++;
        if (outs !== O_NORM || stall_cnt_o !== 16'd0 || stall_cnt4 !== 4'd0) begin
            failures++; $display("FAIL rst_stall_run got=%b/%0d/%0d exp=%b/0/0",
                                 outs, stall_cnt_o, stall_cnt4, O_NORM);
        end
        load_use();
        for (int i = 0; i < 20; i++) step();
        idle();
        #1;
        checks++;
        if (stall_cnt4 !== 4'd15) begin
            failures++; $display("FAIL sat_cnt4 got=%0d exp=15", stall_cnt4);
        end
        checks++;
        if (stall_cnt_o !== 16'd20) begin
            failures++; $display("FAIL sat_cnt16 got=%0d exp=20", stall_cnt_o);
        end
        branch_taken_i = 1'b1;
        for (int i = 0; i < 17; i++) step();
        idle();
        #1;
        checks++;
        if (flush_cnt4 !== 4'd15 || flush_cnt_o !== 16'd17) begin
            failures++; $display("FAIL sat_flush got=%0d/%0d exp=15/17", flush_cnt4, flush_cnt_o);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_load_branch();
        test_match_rules();
        test_busy_mid_stall();
        test_branch_vs_hazard();
        test_reset_mid_stall_and_sat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the saturating performance counters.
REQ-002 SHALL have port clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n_i  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port ex_memread_i  input  1  instruction in EX is a load.
REQ-005 SHALL have port ex_regwrite_i  input  1  instruction in EX writes a register.
REQ-006 SHALL have port ex_wr_addr_i  input  5  destination register of EX instruction (after RegDst mux).
REQ-007 SHALL have port id_rs_i  input  5  rs field of instruction in ID.
REQ-008 SHALL have port id_rt_i  input  5  rt field of instruction in ID.
REQ-009 SHALL have port id_uses_rt_i  input  1  ID instruction reads rt as a source.
REQ-010 SHALL have port id_is_branch_i  input  1  ID instruction is a branch compared in ID.
REQ-011 SHALL have port branch_taken_i  input  1  ID branch resolved taken this cycle.
REQ-012 SHALL have port dmem_busy_i  input  1  data memory not ready; back half of pipeline must hold.
REQ-013 SHALL have ports pc_write_o, if_id_write_o  output  1 each  enable PC / IF-ID register update.
REQ-014 SHALL have port if_id_flush_o  output  1  clear IF-ID to NOP.
REQ-015 SHALL have port id_ex_bubble_o  output  1  zero WB/MEM/EX control fields entering ID-EX.
REQ-016 SHALL have port pipe_freeze_o  output  1  hold ID-EX, EX-MEM, MEM-WB contents.
REQ-017 SHALL have ports stall_cnt_o, flush_cnt_o  output  CNT_W each  saturating stall-cycle and flush counts.

Function
REQ-018 SHALL implement states RUN, STALL, MEM_WAIT with a registered 2-bit remaining-stall counter rem.
REQ-019 SHALL define match = ex_wr_addr_i!=0 and (ex_wr_addr_i==id_rs_i or (id_uses_rt_i and ex_wr_addr_i==id_rt_i)).
REQ-020 SHALL define stall need N: ex_memread_i and match and id_is_branch_i -> 2; ex_memread_i and match -> 1; ex_regwrite_i and match and id_is_branch_i -> 1; else 0.
REQ-021 SHALL give cycle priority: dmem_busy_i, then STALL state, then hazard detect (N>0), then branch_taken_i, else normal.
REQ-022 dmem_busy_i=1 (any state) SHALL drive pc_write_o=0, if_id_write_o=0, pipe_freeze_o=1, id_ex_bubble_o=0, if_id_flush_o=0; rem and pending state held; next state MEM_WAIT, returning to the held state (RUN or STALL) the cycle after dmem_busy_i falls.
REQ-023 In RUN with N>0 and no busy, SHALL drive pc_write_o=0, if_id_write_o=0, id_ex_bubble_o=1 that cycle; N==1 -> stay RUN (no further stall); N==2 -> next state STALL, rem=1.
REQ-024 In STALL without busy, SHALL drive the same stall outputs regardless of hazard inputs, decrement rem, return to RUN when rem reaches 0; total stall = exactly N cycles.
REQ-025 branch_taken_i SHALL be honored only in RUN with N==0 and no busy: if_id_flush_o=1, pc_write_o=1, if_id_write_o=1; ignored in STALL/MEM_WAIT.
REQ-026 Normal cycle SHALL drive pc_write_o=1, if_id_write_o=1, all others 0.
REQ-027 Outputs SHALL be combinational from state, rem and current inputs (same-cycle response, no added latency).
REQ-028 stall_cnt_o SHALL increment on every cycle with id_ex_bubble_o=1 or pipe_freeze_o=1; flush_cnt_o on every cycle with if_id_flush_o=1; both saturate at 2^CNT_W-1, never wrap.

Reset
REQ-029 rst_n_i low at a rising edge SHALL set state RUN, rem=0, both counters 0, regardless of state (including mid-STALL or MEM_WAIT).
REQ-030 While rst_n_i is low, outputs SHALL be pc_write_o=0, if_id_write_o=0, if_id_flush_o=1, id_ex_bubble_o=1, pipe_freeze_o=0.

Verification
REQ-031 Load-use: ex_memread=1, ex_wr_addr=5, id_rs=5, branch=0 -> one cycle pc_write=0, bubble=1, then RUN; stall_cnt=1.
REQ-032 Load-to-branch: ex_memread=1, ex_wr_addr=8, id_rt=8, uses_rt=1, is_branch=1 -> exactly 2 stall cycles though inputs change after cycle 1; stall_cnt=2.
REQ-033 $zero: ex_memread=1, ex_wr_addr=0, id_rs=0 -> no stall, pc_write=1.
REQ-034 Busy mid-STALL: dmem_busy=1 for 3 cycles during STALL rem=1 -> freeze=1 for 3 cycles, then 1 remaining stall cycle, stall_cnt incremented 5 total.
REQ-035 Branch vs hazard same cycle: branch_taken=1 with N=1 -> stall only, flush=0; next clean cycle branch_taken=1 -> flush=1, flush_cnt=1.
REQ-036 Reset mid-STALL and saturation: rst_n low one edge -> RUN, counters 0; CNT_W=4 with 20 stall cycles -> stall_cnt holds 15.
